prbs_stream_gen: RTL and testbench

Parametrised PRBS traffic source for cable/link test, generalising the fixed 32-bit PRBS31 generator. Polynomial is selectable at run time (PRBS7/15/23/31) and the output width is a parameter. Output is an AXI4-Stream master with backpressure, framed by TLAST. Single-bit error injection and beat/frame counters support BER testing against a downstream checker.

---
 rtl/prbs_pkg.sv | 78 +++++++
 rtl/prbs_lfsr_word.sv | 25 ++
 rtl/prbs_stream_gen.sv | 141 ++++++++++++++
 tb/tb_prbs_stream_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and LFSR stepping helpers for the PRBS stream generator.
// The word function runs the serial LFSR dw times; the loop is unrolled in hardware.
package prbs_pkg;
   localparam int MAX_DW = 512;

   localparam int N7  = 7;
   localparam int M7  = 6;
   localparam int N15 = 15;
   localparam int M15 = 14;
   localparam int N23 = 23;
   localparam int M23 = 18;
   localparam int N31 = 31;
   localparam int M31 = 28;

   typedef enum logic [1:0] {
      PRBS7  = 2'd0,
      PRBS15 = 2'd1,
      PRBS23 = 2'd2,
      PRBS31 = 2'd3
   } prbs_mode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } prbs_state_t;

   typedef struct packed {
      logic [30:0]       state;
      logic [MAX_DW-1:0] word;
   } lfsr_res_t;

   function automatic logic [30:0] mode_mask(input prbs_mode_t m);
      case (m)
         PRBS7:   return 31'h0000_007F;
         PRBS15:  return 31'h0000_7FFF;
         PRBS23:  return 31'h007F_FFFF;
         default: return 31'h7FFF_FFFF;
      endcase
   endfunction

   function automatic logic tap(input logic [30:0] s, input prbs_mode_t m);
      case (m)
         PRBS7:   return s[N7-1]  ^ s[M7-1];
         PRBS15:  return s[N15-1] ^ s[M15-1];
         PRBS23:  return s[N23-1] ^ s[M23-1];
         default: return s[N31-1] ^ s[M31-1];
      endcase
   endfunction

   // Zero seeds lock the LFSR, so fall back to the default, then to all-ones.
   function automatic logic [30:0] load_seed(input logic [31:0] seed, input logic [31:0] dflt,
                                             input prbs_mode_t m);
      logic [30:0] s;
      s = 31'(seed & {1'b0, mode_mask(m)});
      if (s == '0) s = 31'(dflt & {1'b0, mode_mask(m)});
      if (s == '0) s = mode_mask(m);
      return s;
   endfunction

   function automatic lfsr_res_t lfsr_word(input logic [30:0] s0, input prbs_mode_t m, input int dw);
      lfsr_res_t   r;
      logic [30:0] s;
      logic        nb;
      s      = s0;
      nb     = 1'b0;
      r.word = '0;
      for (int i = 0; i < MAX_DW; i++) begin
         if (i < dw) begin
            nb = tap(s, m);
            s  = {s[29:0], nb} & mode_mask(m);
            r.word[9'(dw - 1 - i)] = nb;
         end
      end
      r.state = s;
      return r;
   endfunction
endpackage

// File: rtl/prbs_lfsr_word.sv
// Combinational DW-bit advance of the LFSR for the selected polynomial.
module prbs_lfsr_word
   import prbs_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [30:0]   state,
   input  prbs_mode_t    mode,
   output logic [30:0]   next_state,
   output logic [DW-1:0] word
);
   lfsr_res_t res;

   always_comb res = lfsr_word(state, mode, DW);

   assign next_state = res.state;
   assign word       = res.word[DW-1:0];

   generate
      if (DW < MAX_DW) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^res.word[MAX_DW-1:DW];
      end
   endgenerate
endmodule

// File: rtl/prbs_stream_gen.sv
// PRBS AXI4-Stream traffic source with framing, graceful stop, bit-error
// injection and beat/frame counters.
module prbs_stream_gen
   import prbs_pkg::*;
#(
   parameter int          DW           = 32,
   parameter int          FRAME_BEATS  = 256,
   parameter logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          start,
   input  logic          stop,
   input  logic [1:0]    mode,
   input  logic [31:0]   seed,
   input  logic          inject_err,
   output logic          busy,
   output logic [DW-1:0] m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic          m_axis_tlast,
   output logic [31:0]   beat_count,
   output logic [31:0]   frame_count
);
   localparam int             IW       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(FRAME_BEATS - 1);

   prbs_state_t   state, state_n;
   prbs_mode_t    mode_q, step_mode;
   logic [30:0]   lfsr_q, step_in, step_out;
   logic [DW-1:0] data_q, step_word;
   logic          valid_q, last_q, inj_q;
   logic [IW-1:0] idx_q, idx_n;
   logic [31:0]   beat_q, frame_q;
   logic          acc, load, advance, finish;

   assign acc       = valid_q & m_axis_tready;
   assign step_mode = (state == S_IDLE) ? prbs_mode_t'(mode) : mode_q;
   assign step_in   = (state == S_IDLE) ? load_seed(seed, DEFAULT_SEED, prbs_mode_t'(mode)) : lfsr_q;
   assign idx_n     = last_q ? '0 : idx_q + IW'(1);

   prbs_lfsr_word #(.DW(DW)) u_word (
      .state      (step_in),
      .mode       (step_mode),
      .next_state (step_out),
      .word       (step_word)
   );

   always_ff @(posedge clock) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_n;
   end

   // A stop that lands on the accepted TLAST beat skips DRAIN entirely.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            advance = acc;
            if (stop) begin
               if (acc && last_q) begin
                  state_n = S_IDLE;
                  finish  = 1'b1;
               end else begin
                  state_n = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            advance = acc;
            if (acc && last_q) begin
               state_n = S_IDLE;
               finish  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         mode_q  <= PRBS7;
         lfsr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
      end else if (load) begin
         mode_q  <= prbs_mode_t'(mode);
         lfsr_q  <= step_out;
         data_q  <= step_word;
         valid_q <= 1'b1;
         last_q  <= (LAST_IDX == '0);
         idx_q   <= '0;
      end else if (finish) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (advance) begin
         lfsr_q  <= step_out;
         data_q  <= step_word;
         idx_q   <= idx_n;
         last_q  <= (idx_n == LAST_IDX);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         beat_q  <= '0;
         frame_q <= '0;
      end else if (load) begin
         beat_q  <= '0;
         frame_q <= '0;
      end else if (acc) begin
         beat_q <= beat_q + 32'd1;
         if (last_q) frame_q <= frame_q + 32'd1;
      end
   end

   // A pulse arriving with an accept belongs to the following beat.
   always_ff @(posedge clock) begin
      if (!resetn)         inj_q <= 1'b0;
      else if (acc)        inj_q <= inject_err;
      else if (inject_err) inj_q <= 1'b1;
   end

   assign busy          = (state != S_IDLE);
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;
   assign m_axis_tdata  = data_q ^ DW'(inj_q & valid_q);
   assign beat_count    = beat_q;
   assign frame_count   = frame_q;
endmodule

// File: tb/tb_prbs_stream_gen.sv
// Randomised bench for prbs_stream_gen: serial-LFSR stream model plus
// per-cycle comparison, with literal expectations that anchor the model.
module tb_prbs_stream_gen;
   localparam int          DW  = 32;
   localparam int          FB  = 4;
   localparam logic [31:0] DEF = 32'hFFFF_FFFF;

   logic          clock = 1'b0;
   logic          resetn, start, stop, inject_err, tready;
   logic [1:0]    mode;
   logic [31:0]   seed;
   logic          busy, tvalid, tlast;
   logic [DW-1:0] tdata;
   logic [31:0]   beat_count, frame_count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   prbs_stream_gen #(.DW(DW), .FRAME_BEATS(FB), .DEFAULT_SEED(DEF)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .start         (start),
      .stop          (stop),
      .mode          (mode),
      .seed          (seed),
      .inject_err    (inject_err),
      .busy          (busy),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast),
      .beat_count    (beat_count),
      .frame_count   (frame_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a serial LFSR emitting bits MSB-first into words,
   // plus stream bookkeeping driven by the handshake rules.
   logic [31:0]   m_s;
   int            m_n, m_m;
   logic [DW-1:0] m_word;
   bit            m_busy, m_valid, m_inj, m_stopping;
   int            m_idx;
   int unsigned   m_beats, m_frames;

   function automatic logic [DW-1:0] next_word();
      logic [DW-1:0] w;
      logic [31:0]   mask;
      bit            nb;
      mask = (32'd1 << m_n) - 32'd1;
      for (int i = DW - 1; i >= 0; i--) begin
         nb   = m_s[m_n-1] ^ m_s[m_m-1];
         m_s  = ((m_s << 1) | 32'(nb)) & mask;
         w[i] = nb;
      end
      return w;
   endfunction

   task automatic model_start();
      logic [31:0] mask;
      case (mode)
         2'd0:    begin m_n = 7;  m_m = 6;  end
         2'd1:    begin m_n = 15; m_m = 14; end
         2'd2:    begin m_n = 23; m_m = 18; end
         default: begin m_n = 31; m_m = 28; end
      endcase
      mask = (32'd1 << m_n) - 32'd1;
      m_s  = seed & mask;
      if (m_s == 0) m_s = DEF & mask;
      if (m_s == 0) m_s = mask;
      m_word     = next_word();
      m_valid    = 1;
      m_busy     = 1;
      m_idx      = 0;
      m_beats    = 0;
      m_frames   = 0;
      m_stopping = 0;
   endtask

   always @(posedge clock) begin
      bit macc, mlast;
      if (!resetn) begin
         m_busy = 0; m_valid = 0; m_word = '0; m_inj = 0; m_idx = 0;
         m_beats = 0; m_frames = 0; m_stopping = 0;
      end else if (!m_busy) begin
         if (inject_err) m_inj = 1;
         if (start) model_start();
      end else begin
         macc  = m_valid && tready;
         mlast = (m_idx == FB - 1);
         if (macc) begin
            m_beats++;
            if (mlast) m_frames++;
         end
         if (stop) m_stopping = 1;
         m_inj = macc ? inject_err : (m_inj | inject_err);
         if (macc) begin
            if (mlast && m_stopping) begin
               m_busy  = 0;
               m_valid = 0;
            end else begin
               m_word = next_word();
               m_idx  = (m_idx + 1) % FB;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy",        busy,        m_busy);
         chk("tvalid",      tvalid,      m_valid);
         chk("tlast",       tlast,       m_valid && (m_idx == FB - 1));
         chk("beat_count",  beat_count,  m_beats);
         chk("frame_count", frame_count, m_frames);
         if (m_valid) chk("tdata", tdata, m_word ^ DW'(m_inj));
      end
   end

   task automatic pulse_start(input logic [1:0] md, input logic [31:0] sd);
      mode = md; seed = sd; start = 1;
      @(negedge clock);
      start = 0;
   endtask

   task automatic stop_and_wait();
      int n;
      tready = 1; stop = 1;
      @(negedge clock);
      stop = 0;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      resetn = 0; start = 0; stop = 0; inject_err = 0; tready = 0; mode = 0; seed = 0;
      repeat (3) @(negedge clock);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata",  tdata, 0);
      chk("rst_busy",   busy, 0);
      chk("rst_beats",  beat_count, 0);
      chk_en = 1;
      resetn = 1;
      @(negedge clock);

      // PRBS7 from all-ones: known first byte, word period of 127.
      tready = 1;
      pulse_start(2'd0, 32'h7F);
      chk("prbs7_first", tdata[31:24], 8'h02);
      repeat (127) @(negedge clock);
      chk("prbs7_period", tdata[31:24], 8'h02);
      chk("prbs7_beats",  beat_count, 127);
      stop_and_wait();

      // PRBS31 with zero seed falls back to all-ones.
      pulse_start(2'd3, 32'h0);
      chk("prbs31_first", tdata, 32'h0000_000E);
      repeat (10000) @(negedge clock);
      chk("prbs31_beats", beat_count, 10000);
      stop_and_wait();

      // Random backpressure, random inject pulses, random polynomial/seed.
      pulse_start(2'($urandom_range(0, 3)), $urandom);
      for (int c = 0; c < 2000; c++) begin
         if (m_beats == 40) break;
         tready     = 1'($urandom_range(0, 1));
         inject_err = ($urandom_range(0, 7) == 0);
         @(negedge clock);
      end
      tready = 0; inject_err = 0;
      chk("rand_beats",  beat_count, 40);
      chk("rand_frames", frame_count, 10);
      stop_and_wait();

      // Stop at frame index 1: indices 2 and 3 still go out.
      tready = 1;
      pulse_start(2'd0, 32'h7F);
      @(negedge clock);
      stop_and_wait();
      chk("stop_beats",  beat_count, 4);
      chk("stop_frames", frame_count, 1);
      chk("stop_tvalid", tvalid, 0);
      pulse_start(2'd0, 32'h7F);
      chk("restart_first", tdata[31:24], 8'h02);

      // Two inject pulses during a stall flip only the stalled beat's bit 0.
      tready = 0;
      @(negedge clock);
      inject_err = 1; @(negedge clock);
      inject_err = 0; @(negedge clock);
      inject_err = 1; @(negedge clock);
      inject_err = 0; @(negedge clock);
      chk("inj_stalled", tdata ^ m_word, 32'h1);
      tready = 1;
      repeat (5) @(negedge clock);
      chk("inj_after", tdata ^ m_word, 32'h0);

      // Reset in the middle of a frame.
      resetn = 0;
      @(negedge clock);
      chk("mrst_tvalid", tvalid, 0);
      chk("mrst_busy",   busy, 0);
      chk("mrst_tdata",  tdata, 0);
      chk("mrst_tlast",  tlast, 0);
      chk("mrst_beats",  beat_count, 0);
      chk("mrst_frames", frame_count, 0);
      resetn = 1;
      @(negedge clock);
      pulse_start(2'd0, 32'h7F);
      chk("mrst_first", tdata[31:24], 8'h02);
      stop_and_wait();

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
